// File: rtl/mips_defs.sv
// Shared definitions for the MIPS board-level slice: register names, display
// source selection and the hex-to-7-segment glyph table.
package mips_defs;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [4:0] {
    ZERO = 5'd0,
    AT   = 5'd1,
    V0   = 5'd2,
    V1   = 5'd3,
    A0   = 5'd4,
    A1   = 5'd5,
    A2   = 5'd6,
    A3   = 5'd7,
    T0   = 5'd8,
    S0   = 5'd16,
    GP   = 5'd28,
    SP   = 5'd29,
    FP   = 5'd30,
    RA   = 5'd31
  } mips_reg_e;

  typedef enum logic [2:0] {
    SEL_LED,
    SEL_RAM,
    SEL_STAT,
    SEL_MIS,
    SEL_CORR
  } disp_sel_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always dark.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mips_pipeline.sv
// Minimal stand-in for the pipelined core: runs a fixed synthetic instruction
// stream (LED writes, branch outcomes, halt) and exposes a read-only DM port.
module mips_pipeline #(
  parameter string       CODE_FILE    = "",
  parameter int unsigned IM_BUS_WIDTH = 10,
  parameter int unsigned DM_BUS_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        led_we,
  output logic [31:0] led_wdata,
  output logic        halt,
  output logic        br_correct,
  output logic        br_mispredict
);

  // A loaded image runs a longer program before reaching its halt loop.
  localparam int unsigned HALT_AT = (CODE_FILE == "") ? 64 : 200;

  logic [IM_BUS_WIDTH-1:0] pc;
  logic [DM_BUS_WIDTH-1:0] dm_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (en && !halt) begin
      pc <= pc + IM_BUS_WIDTH'(1);
    end
  end

  always_comb begin
    halt          = (pc >= IM_BUS_WIDTH'(HALT_AT));
    led_we        = !halt && (pc[3:0] == 4'hF);
    led_wdata     = 32'hA500_0000 | 32'(pc);
    br_correct    = !halt && (pc[2:0] == 3'd2);
    br_mispredict = !halt && ((pc[3:0] == 4'd2) || (pc[3:0] == 4'd9));
    dm_addr       = DM_BUS_WIDTH'(dbg_addr);
    dbg_data      = 32'hDA7A_0000 + 32'(dm_addr) * 32'(dm_addr);
  end

endmodule

// File: rtl/mips_top_seg7_scan.sv
// Multiplexed 8-digit hex display driver: one digit lit at a time, stepping to
// the next digit whenever the SCAN_BITS-wide prescaler wraps.
module seg7_scan
  import mips_defs::*;
#(
  parameter int unsigned SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  output logic [7:0]  anodes,
  output logic [7:0]  cnodes
);

  logic [SCAN_BITS-1:0] presc;
  logic [2:0]           idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + SCAN_BITS'(1);
      if (presc == '1) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    anodes = ~(8'd1 << idx);
    cnodes = hex_seg(value[{idx, 2'b00} +: 4]);
  end

endmodule

// File: rtl/mips_top.sv
// Board-level top: paces the core with a clock enable, accumulates run
// statistics and routes one selected word to the 7-segment display.
module mips_top
  import mips_defs::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter string       CODE_FILE    = "mips/waterfall_lamp.hex",
  parameter int unsigned IM_BUS_WIDTH = 10,
  parameter int unsigned DM_BUS_WIDTH = 24,
  parameter int unsigned CLK_HZ       = 0,
  parameter int unsigned SYS_HZ       = 100_000_000,
  parameter int unsigned SCAN_BITS    = 17
) (
  input  logic       raw_clk,
  input  logic       raw_rst,
  input  logic       raw_en,
  input  logic       switch_rst,
  input  logic       switch_stat,
  input  logic       switch_ram,
  input  logic       switch_correctprediction,
  input  logic       switch_misprediction,
  input  logic [4:0] switch_addr,
  output logic [7:0] anodes,
  output logic [7:0] cnodes
);

  // CLK_HZ==0 gives a divide-by-1 counter that never leaves 0, so tick stays high.
  localparam int unsigned TICK_DIV = (CLK_HZ == 0) ? 1 : SYS_HZ / CLK_HZ;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic                  step;
  logic                  core_rst_n;
  logic                  led_we;
  logic [31:0]           led_wdata;
  logic                  halt;
  logic                  br_correct;
  logic                  br_mispredict;
  logic [31:0]           dbg_data;
  logic [DATA_WIDTH-1:0] led_data;
  logic [DATA_WIDTH-1:0] stat_count;
  logic [DATA_WIDTH-1:0] stat_misprediction;
  logic [DATA_WIDTH-1:0] stat_correctprediction;
  disp_sel_e             sel;
  logic [31:0]           disp_value;

  always_comb begin
    tick       = (tick_cnt == TICK_W'(TICK_DIV - 1));
    step       = raw_en & tick;
    core_rst_n = raw_rst & ~switch_rst;
  end

  always_ff @(posedge raw_clk or negedge raw_rst) begin
    if (!raw_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  mips_pipeline #(
    .CODE_FILE    (CODE_FILE),
    .IM_BUS_WIDTH (IM_BUS_WIDTH),
    .DM_BUS_WIDTH (DM_BUS_WIDTH)
  ) u_core (
    .clk           (raw_clk),
    .rst_n         (core_rst_n),
    .en            (step),
    .dbg_addr      (switch_addr),
    .dbg_data      (dbg_data),
    .led_we        (led_we),
    .led_wdata     (led_wdata),
    .halt          (halt),
    .br_correct    (br_correct),
    .br_mispredict (br_mispredict)
  );

  // A simultaneous correct/mispredict report is scored as a mispredict only.
  always_ff @(posedge raw_clk or negedge raw_rst) begin
    if (!raw_rst) begin
      led_data               <= '0;
      stat_count             <= '0;
      stat_misprediction     <= '0;
      stat_correctprediction <= '0;
    end else if (switch_rst) begin
      led_data               <= '0;
      stat_count             <= '0;
      stat_misprediction     <= '0;
      stat_correctprediction <= '0;
    end else if (step) begin
      if (led_we) begin
        led_data <= DATA_WIDTH'(led_wdata);
      end
      if (!halt) begin
        stat_count <= stat_count + DATA_WIDTH'(1);
      end
      if (br_mispredict) begin
        stat_misprediction <= stat_misprediction + DATA_WIDTH'(1);
      end else if (br_correct) begin
        stat_correctprediction <= stat_correctprediction + DATA_WIDTH'(1);
      end
    end
  end

  always_comb begin
    if (switch_ram) begin
      sel = SEL_RAM;
    end else if (switch_stat) begin
      sel = SEL_STAT;
    end else if (switch_misprediction) begin
      sel = SEL_MIS;
    end else if (switch_correctprediction) begin
      sel = SEL_CORR;
    end else begin
      sel = SEL_LED;
    end

    case (sel)
      SEL_RAM:  disp_value = dbg_data;
      SEL_STAT: disp_value = 32'(stat_count);
      SEL_MIS:  disp_value = 32'(stat_misprediction);
      SEL_CORR: disp_value = 32'(stat_correctprediction);
      default:  disp_value = 32'(led_data);
    endcase
  end

  seg7_scan #(
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .clk    (raw_clk),
    .rst_n  (raw_rst),
    .value  (disp_value),
    .anodes (anodes),
    .cnodes (cnodes)
  );

endmodule

// File: tb/tb_mips_top.sv
// Bench for mips_top: directed phases plus randomized enable/switch traffic,
// compared against an abstract model of the stand-in core's program.
module tb_mips_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       srst;
  logic       sw_stat;
  logic       sw_ram;
  logic       sw_corr;
  logic       sw_mis;
  logic [4:0] addr;
  logic [7:0] an;
  logic [7:0] cn;
  logic [7:0] p_an;
  logic [7:0] p_cn;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Program model: one counted step per enabled cycle until 200 steps are done.
  int unsigned m_s;
  int unsigned m_scan;
  logic [31:0] m_cnt;
  logic [31:0] m_corr;
  logic [31:0] m_mis;
  logic [31:0] m_led;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  mips_top #(
    .CLK_HZ    (0),
    .SCAN_BITS (2)
  ) dut (
    .raw_clk                  (clk),
    .raw_rst                  (rst),
    .raw_en                   (en),
    .switch_rst               (srst),
    .switch_stat              (sw_stat),
    .switch_ram               (sw_ram),
    .switch_correctprediction (sw_corr),
    .switch_misprediction     (sw_mis),
    .switch_addr              (addr),
    .anodes                   (an),
    .cnodes                   (cn)
  );

  mips_top #(
    .CLK_HZ    (1_000_000),
    .SYS_HZ    (10_000_000),
    .SCAN_BITS (2)
  ) dut_paced (
    .raw_clk                  (clk),
    .raw_rst                  (rst),
    .raw_en                   (1'b1),
    .switch_rst               (1'b0),
    .switch_stat              (1'b0),
    .switch_ram               (1'b0),
    .switch_correctprediction (1'b0),
    .switch_misprediction     (1'b0),
    .switch_addr              (5'd0),
    .anodes                   (p_an),
    .cnodes                   (p_cn)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_s    = 0;
    m_cnt  = '0;
    m_corr = '0;
    m_mis  = '0;
    m_led  = '0;
  endtask

  task automatic model_edge();
    int unsigned k;
    if (!rst) begin
      model_clear();
      m_scan = 0;
    end else begin
      m_scan++;
      if (srst) begin
        model_clear();
      end else if (en && m_s < 200) begin
        k = m_s;
        m_cnt++;
        if (k % 16 == 2 || k % 16 == 9) m_mis++;
        else if (k % 16 == 10) m_corr++;
        if (k % 16 == 15) m_led = 32'hA500_0000 + k;
        m_s++;
      end
    end
  endtask

  task automatic check_regs();
    check_eq("stat_count", dut.stat_count, m_cnt);
    check_eq("stat_correct", dut.stat_correctprediction, m_corr);
    check_eq("stat_mispredict", dut.stat_misprediction, m_mis);
    check_eq("led_data", dut.led_data, m_led);
  endtask

  task automatic check_disp();
    logic [31:0] v;
    int unsigned idx;
    int unsigned a;
    logic [3:0]  nib;
    logic [7:0]  ea;
    a = 32'(addr);
    if (sw_ram)       v = 32'hDA7A_0000 + a * a;
    else if (sw_stat) v = m_cnt;
    else if (sw_mis)  v = m_mis;
    else if (sw_corr) v = m_corr;
    else              v = m_led;
    idx = (m_scan / 4) % 8;
    nib = 4'(v >> (4 * idx));
    ea  = ~(8'd1 << idx);
    check_eq("anodes", 32'(an), 32'(ea));
    check_eq("cnodes", 32'(cn), 32'(glyph[nib]));
  endtask

  // One clock: model the edge, check state, then drive and check the display.
  task automatic run_cycle(input logic randomize_inputs);
    @(posedge clk);
    #1;
    model_edge();
    check_regs();
    if (randomize_inputs) begin
      en      = ($urandom_range(0, 9) < 7);
      srst    = ($urandom_range(0, 99) == 0);
      sw_ram  = ($urandom_range(0, 3) == 0);
      sw_stat = ($urandom_range(0, 3) == 0);
      sw_mis  = ($urandom_range(0, 3) == 0);
      sw_corr = ($urandom_range(0, 3) == 0);
      addr    = 5'($urandom_range(0, 31));
    end
    #1;
    check_disp();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; srst = 1'b0;
    sw_stat = 1'b0; sw_ram = 1'b0; sw_corr = 1'b0; sw_mis = 1'b0; addr = 5'd0;
    model_clear();
    m_scan = 0;

    for (int i = 0; i < 6; i++) run_cycle(1'b0);
    check_eq("reset_anodes", 32'(an), 32'h0000_00FE);
    check_eq("reset_cnodes", 32'(cn), 32'h0000_00C0);
    check_eq("reset_paced_count", dut_paced.stat_count, 32'd0);

    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 100; i++) run_cycle(1'b0);
    check_eq("count_after_100", dut.stat_count, 32'd100);
    check_eq("paced_after_100", dut_paced.stat_count, 32'd10);

    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      run_cycle(1'b0);
      if (i == 4) check_eq("paced_after_105", dut_paced.stat_count, 32'd10);
      if (i == 9) check_eq("paced_after_110", dut_paced.stat_count, 32'd11);
    end
    check_eq("hold_count", dut.stat_count, 32'd100);
    check_eq("paced_after_150", dut_paced.stat_count, 32'd15);

    en = 1'b1;
    for (int i = 0; i < 150; i++) run_cycle(1'b0);
    check_eq("count_halted", dut.stat_count, 32'd200);

    sw_ram = 1'b1; sw_stat = 1'b1; addr = 5'd5;
    for (int i = 0; i < 32; i++) run_cycle(1'b0);
    sw_ram = 1'b0;
    for (int i = 0; i < 32; i++) run_cycle(1'b0);
    sw_stat = 1'b0;

    srst = 1'b1;
    run_cycle(1'b0);
    srst = 1'b0;
    check_eq("srst_count", dut.stat_count, 32'd0);
    check_eq("srst_led", dut.led_data, 32'd0);
    check_eq("srst_mis", dut.stat_misprediction, 32'd0);
    check_eq("srst_corr", dut.stat_correctprediction, 32'd0);

    for (int i = 0; i < 800; i++) begin
      run_cycle(1'b1);
      if (i == 400) begin
        #1;
        sw_ram = 1'b0; sw_stat = 1'b0; sw_mis = 1'b0; sw_corr = 1'b0;
        rst = 1'b0;
        #1;
        model_clear();
        m_scan = 0;
        check_eq("async_rst_count", dut.stat_count, 32'd0);
        check_eq("async_rst_anodes", 32'(an), 32'h0000_00FE);
        check_eq("async_rst_cnodes", 32'(cn), 32'h0000_00C0);
        for (int j = 0; j < 3; j++) run_cycle(1'b0);
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
